debounce_bank: RTL and testbench

- Parametrised multi-channel debouncer for switch and key inputs. It is the next generation of the fixed 18-bit divided-clock sampler.
- Every input is synchronised into the system clock domain. The block then applies counter-based stability filtering on a shared sample tick.
- It emits debounced levels plus one-cycle rise/fall pulses per channel.
- Sits between board I/O pins and the control logic (mode select, step keys). Everything runs on the single system clock; no derived clocks.

---
 rtl/debounce_bank.sv | 83 ++++++++
 tb/tb_debounce_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel switch/key debouncer: two-flop synchronisers, a shared free-running
// prescaler tick and per-channel stability counters with registered edge pulses.
module debounce_bank #(
    parameter int   N            = 18,
    parameter int   DIV_BITS     = 16,
    parameter int   STABLE_TICKS = 4,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_in,
    output logic [N-1:0] key_out,
    output logic [N-1:0] key_rise,
    output logic [N-1:0] key_fall,
    output logic         any_change,
    output logic         tick
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);

    logic [N-1:0]          sync1_q, sync1_d;
    logic [N-1:0]          sync2_q, sync2_d;
    logic [N-1:0]          out_q, out_d;
    logic [N-1:0]          rise_q, rise_d;
    logic [N-1:0]          fall_q, fall_d;
    logic                  any_q, any_d;
    logic [DIV_BITS-1:0]   presc_q, presc_d;
    logic [N-1:0][7:0]     cnt_q, cnt_d;

    assign tick = &presc_q;

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        presc_d = presc_q + DIV_BITS'(1);
        out_d   = out_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N; i++) begin
            // Any sample that agrees with the output restarts qualification, tick or not.
            if (sync2_q[i] == out_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (tick && cnt_q[i] == CNT_LAST) begin
                out_d[i]  = sync2_q[i];
                cnt_d[i]  = 8'd0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else if (tick) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {N{RESET_VAL}};
            sync2_q <= {N{RESET_VAL}};
            out_q   <= {N{RESET_VAL}};
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_out    = out_q;
    assign key_rise   = rise_q;
    assign key_fall   = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: instance a (DIV_BITS=2, STABLE_TICKS=3, reset 0)
// and instance b (DIV_BITS=1, STABLE_TICKS=1, reset 1), hand-computed expectations.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] key_a, key_b;
    logic [3:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
    logic       any_a, tick_a, any_b, tick_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         n;
        logic [3:0] key;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
        logic       tick;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    debounce_bank #(.N(4), .DIV_BITS(2), .STABLE_TICKS(3), .RESET_VAL(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .key_in(key_a), .key_out(out_a), .key_rise(rise_a),
        .key_fall(fall_a), .any_change(any_a), .tick(tick_a)
    );

    debounce_bank #(.N(4), .DIV_BITS(1), .STABLE_TICKS(1), .RESET_VAL(1'b1)) dut_b (
        .clk(clk), .rst(rst_b), .key_in(key_b), .key_out(out_b), .key_rise(rise_b),
        .key_fall(fall_b), .any_change(any_b), .tick(tick_b)
    );

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic a);
        chk({nm, ".out"}, out_a, o);
        chk({nm, ".rise"}, rise_a, r);
        chk({nm, ".fall"}, fall_a, f);
        chk({nm, ".any"}, {3'b0, any_a}, {3'b0, a});
    endtask

    task automatic chk_b(input string nm, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic a);
        chk({nm, ".out"}, out_b, o);
        chk({nm, ".rise"}, rise_b, r);
        chk({nm, ".fall"}, fall_b, f);
        chk({nm, ".any"}, {3'b0, any_b}, {3'b0, a});
    endtask

    initial begin
        int k;
        // n edges after driving key, then expected out/rise/fall/any/tick (edge index in comment)
        tbl[0]  = '{1,  4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}; // e0
        tbl[1]  = '{2,  4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1}; // e2
        tbl[2]  = '{1,  4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}; // e3
        tbl[3]  = '{7,  4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1}; // e10
        tbl[4]  = '{1,  4'hF, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0}; // e11
        tbl[5]  = '{1,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0}; // e12
        tbl[6]  = '{10, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1}; // e22
        tbl[7]  = '{1,  4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0}; // e23
        tbl[8]  = '{1,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}; // e24
        tbl[9]  = '{10, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1}; // e34
        tbl[10] = '{1,  4'h1, 4'h1, 4'h1, 4'h0, 1'b1, 1'b0}; // e35
        tbl[11] = '{1,  4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0}; // e36
        tbl[12] = '{10, 4'hB, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1}; // e46
        tbl[13] = '{1,  4'hB, 4'hB, 4'hA, 4'h0, 1'b1, 1'b0}; // e47
        tbl[14] = '{1,  4'hB, 4'hB, 4'h0, 4'h0, 1'b0, 1'b0}; // e48

        rst_a = 1'b1;
        rst_b = 1'b1;
        key_a = 4'hF;
        key_b = 4'hF;
        for (int i = 0; i < 3; i++) begin
            adv(1);
            chk_a($sformatf("rst_a%0d", i), 4'h0, 4'h0, 4'h0, 1'b0);
        end
        rst_a = 1'b0;

        for (int i = 0; i < 15; i++) begin
            key_a = tbl[i].key;
            adv(tbl[i].n);
            chk_a($sformatf("vec%0d", i), tbl[i].out, tbl[i].rise, tbl[i].fall, tbl[i].any);
            chk($sformatf("vec%0d.tick", i), {3'b0, tick_a}, {3'b0, tbl[i].tick});
        end

        // Bounce on channel 2: 5 cycles high, 2 low, never enough ticks to qualify.
        for (int r = 0; r < 10; r++) begin
            key_a = 4'hF;
            for (int j = 0; j < 5; j++) begin
                adv(1);
                chk_a($sformatf("bounce%0d_h%0d", r, j), 4'hB, 4'h0, 4'h0, 1'b0);
            end
            key_a = 4'hB;
            for (int j = 0; j < 2; j++) begin
                adv(1);
                chk_a($sformatf("bounce%0d_l%0d", r, j), 4'hB, 4'h0, 4'h0, 1'b0);
            end
        end
        key_a = 4'hF;
        k = 0;
        while (k < 20) begin
            adv(1);
            k++;
            if (out_a[2]) break;
        end
        chk("hold_latency_ok", {3'b0, (k >= 11 && k <= 14)}, 4'h1);
        chk_a("hold_rise", 4'hF, 4'h4, 4'h0, 1'b1);
        adv(1);
        chk_a("hold_after", 4'hF, 4'h0, 4'h0, 1'b0);

        // Reset in the middle of a release qualification.
        key_a = 4'h0;
        adv(6);
        chk_a("midq_pre", 4'hF, 4'h0, 4'h0, 1'b0);
        #2 rst_a = 1'b1;
        #1;
        chk_a("midq_rst", 4'h0, 4'h0, 4'h0, 1'b0);
        chk("midq_rst.tick", {3'b0, tick_a}, 4'h0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        key_a = 4'hF;
        for (int i = 0; i < 11; i++) begin
            adv(1);
            chk_a($sformatf("midq_e%0d", i), 4'h0, 4'h0, 4'h0, 1'b0);
        end
        adv(1);
        chk_a("midq_e11", 4'hF, 4'hF, 4'h0, 1'b1);
        adv(1);
        chk_a("midq_e12", 4'hF, 4'h0, 4'h0, 1'b0);

        // Instance b: reset value 1, one-tick qualification, tick on odd edges.
        chk_b("b_rst", 4'hF, 4'h0, 4'h0, 1'b0);
        rst_b = 1'b0;
        adv(1);
        chk("b_e0.tick", {3'b0, tick_b}, 4'h1);
        chk_b("b_e0", 4'hF, 4'h0, 4'h0, 1'b0);
        adv(1);
        chk("b_e1.tick", {3'b0, tick_b}, 4'h0);
        adv(2);
        key_b = 4'h0;
        adv(1);
        key_b = 4'hF;
        for (int i = 5; i <= 8; i++) begin
            adv(1);
            chk_b($sformatf("b_glitch_e%0d", i), 4'hF, 4'h0, 4'h0, 1'b0);
        end
        adv(1);
        key_b = 4'h0;
        for (int i = 10; i <= 12; i++) begin
            adv(1);
            chk_b($sformatf("b_low_e%0d", i), 4'hF, 4'h0, 4'h0, 1'b0);
        end
        adv(1);
        chk_b("b_fall_e13", 4'h0, 4'h0, 4'hF, 1'b1);
        adv(1);
        chk_b("b_e14", 4'h0, 4'h0, 4'h0, 1'b0);
        key_b = 4'hF;
        adv(2);
        chk_b("b_e16", 4'h0, 4'h0, 4'h0, 1'b0);
        adv(1);
        chk_b("b_rise_e17", 4'hF, 4'hF, 4'h0, 1'b1);
        adv(1);
        chk_b("b_e18", 4'hF, 4'h0, 4'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
